instr_fetch_unit: RTL and testbench
===================================

// Module: instr_fetch_unit
// PURPOSE
//  Fetch stage directly upstream of the control decoder. Owns the PC and requests words
//  from instruction memory over a req/ack handshake. Holds the fetched word in an
//  instruction register and presents opcode[5:0] = instr[31:26] to the decoder.
//  Computes next PC from the decoder's jump/Branch outputs and the ALU zero flag.
// PARAMETERS
//  ADDR_W    32  PC / instruction-memory address width
//  RESET_PC  0   PC value loaded on reset (word aligned)
//  MAX_WAIT  16  cycles in REQ without imem_ack before fetch_fault (>=1)
// PORTS
//  clk          in   1       single clock, all state on rising edge
//  reset        in   1       asynchronous, active-high
//  imem_req     out  1       fetch request, held until imem_ack
//  imem_addr    out  ADDR_W  fetch address (= pc), stable while imem_req=1
//  imem_ack     in   1       memory accepts request; imem_rdata valid same cycle
//  imem_rdata   in   32      instruction word
//  stall        in   1       downstream cannot retire current instruction this cycle
//  branch       in   1       decoder Branch
//  zero         in   1       ALU zero flag
//  jump         in   1       decoder jump
//  branch_imm   in   16      instr[15:0], signed word offset
//  jump_target  in   26      instr[25:0], word index
//  instr        out  32      instruction register
//  opcode       out  6       instr[31:26], to decoder
//  instr_valid  out  1       instr/opcode valid for the downstream stage
//  pc           out  ADDR_W  address of the instruction in instr
//  fetch_fault  out  1       sticky: memory failed to ack within MAX_WAIT
// BEHAVIOUR
//  Reset (async assert): state=REQ, pc=RESET_PC, instr=0, instr_valid=0, imem_req=0,
//   fetch_fault=0, wait_cnt=0. imem_req is registered-low during reset; it rises the
//   first clk edge after reset deasserts.
//  FSM states: REQ, ISSUE, FAULT.
//   REQ: imem_req=1, imem_addr=pc. On imem_ack: instr<=imem_rdata, wait_cnt<=0 -> ISSUE.
//    No ack: wait_cnt++; when wait_cnt reaches MAX_WAIT-1 with no ack -> FAULT.
//   ISSUE: instr_valid=1, imem_req=0. If stall=1: hold everything.
//    If stall=0: pc<=next_pc -> REQ (instr_valid drops next cycle).
//   FAULT: imem_req=0, instr_valid=0, fetch_fault=1; leaves only via reset.
//  next_pc (pc4 = pc+4, modulo 2^ADDR_W, wrap silently):
//   jump=1            -> {pc4[ADDR_W-1:28], jump_target, 2'b00}
//   branch&zero       -> pc4 + (sign_ext(branch_imm) << 2), modulo 2^ADDR_W
//   otherwise         -> pc4
//   jump and branch both 1: jump wins. X on branch/jump/zero is not tolerated; bench asserts.
//  pc[1:0] is always 0; RESET_PC low bits are forced to 0.
//  Latency: ack in first REQ cycle -> instr_valid on the next cycle; min 2 cycles/instruction.
//  imem_ack outside REQ is ignored. imem_rdata is sampled only on the ack cycle.
//  imem_req/imem_addr do not change while waiting for ack.
//  Reset mid-operation: outstanding request abandoned, a late ack after reset is ignored
//   until REQ is re-entered.
//  Opcode values are not decoded here. Unknown opcodes (>17) flow through.
//  Redirect happens only through jump/branch.
// STRUCTURE
//  Shared header mips_defs.vh: opcode constants (R-type 0-6, I-type 7-13, OP_LW=14,
//   OP_SW=15, OP_BR=16, OP_J=17), field slices (OPC_HI=31, OPC_LO=26), FSM state codes.
//  One combinational sub-module: next_pc_calc (pc, jump, branch, zero, branch_imm,
//   jump_target -> next_pc).
//  FSM, wait counter, PC register and IR live in the top.
// TESTING
//  1 reset high 3 cycles, release -> pc=0, imem_req=1 next edge, imem_addr=0, outputs 0 during reset.
//  2 ack same cycle, rdata=0x3800_0005, stall=0, no branch/jump:
//    instr_valid 1 cycle, opcode=14, next pc=4. Repeat with ack delayed 3 cycles.
//  3 pc=0x40, branch=1, zero=1, imm=0xFFFF -> next pc=0x40. zero=0 -> next pc=0x44.
//  4 pc=0xF000_0010, jump=1, branch=1, target=0x0000100 -> next pc=0xF000_0400.
//  5 stall=1 for 4 cycles in ISSUE -> instr, pc, instr_valid held, imem_req=0.
//    stall=0 -> advance.
//  6 MAX_WAIT=8, never ack -> fetch_fault=1 after 8 REQ cycles, req low.
//    Async reset mid-wait clears all; pc=0xFFFF_FFFC with no branch wraps to 0.

Source files
------------

// File: rtl/instr_fetch_unit_pkg.sv
// Shared definitions for the fetch stage: opcode map, instruction field slices
// and FSM state encoding.
package instr_fetch_unit_pkg;

    localparam int OPC_HI = 31;
    localparam int OPC_LO = 26;

    // Opcode map as seen by the downstream decoder; fetch passes opcodes through untouched.
    localparam logic [5:0] OP_RTYPE_FIRST = 6'd0;
    localparam logic [5:0] OP_RTYPE_LAST  = 6'd6;
    localparam logic [5:0] OP_ITYPE_FIRST = 6'd7;
    localparam logic [5:0] OP_ITYPE_LAST  = 6'd13;
    localparam logic [5:0] OP_LW          = 6'd14;
    localparam logic [5:0] OP_SW          = 6'd15;
    localparam logic [5:0] OP_BR          = 6'd16;
    localparam logic [5:0] OP_J           = 6'd17;

    typedef enum logic [1:0] {
        ST_REQ   = 2'd0,
        ST_ISSUE = 2'd1,
        ST_FAULT = 2'd2
    } fetch_state_e;

    function automatic logic [5:0] opcode_of(input logic [31:0] word);
        return word[OPC_HI:OPC_LO];
    endfunction

endpackage

// File: rtl/instr_fetch_unit_if.sv
// Instruction-memory request/acknowledge bus between the fetch unit and memory.
interface instr_fetch_unit_if #(
    parameter int ADDR_W = 32
);
    logic              imem_req;
    logic [ADDR_W-1:0] imem_addr;
    logic              imem_ack;
    logic [31:0]       imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ack,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ack,
        output imem_rdata
    );
endinterface

// File: rtl/instr_fetch_unit_next_pc_calc.sv
// Next-PC selection: jump beats taken branch, otherwise sequential pc+4.
module next_pc_calc #(
    parameter int ADDR_W = 32
) (
    input  logic [ADDR_W-1:0] pc,
    input  logic              jump,
    input  logic              branch,
    input  logic              zero,
    input  logic [15:0]       branch_imm,
    input  logic [25:0]       jump_target,
    output logic [ADDR_W-1:0] next_pc
);
    logic [ADDR_W-1:0]        pc4;
    logic signed [ADDR_W-1:0] br_off;

    assign pc4    = pc + ADDR_W'(4);
    // Word offset scaled to bytes and sign-extended to the full address width.
    assign br_off = {{(ADDR_W-18){branch_imm[15]}}, branch_imm, 2'b00};

    always_comb begin
        next_pc = pc4;
        if (jump) begin
            next_pc = {pc4[ADDR_W-1:28], jump_target, 2'b00};
        end else if (branch && zero) begin
            next_pc = pc4 + $unsigned(br_off);
        end
    end
endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: owns the PC, requests words over the imem handshake and holds
// the fetched instruction for the decoder until it is retired.
module instr_fetch_unit
    import instr_fetch_unit_pkg::*;
#(
    parameter int                ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter int                MAX_WAIT = 16
) (
    input  logic                clk,
    input  logic                reset,
    instr_fetch_unit_if.master  imem,
    input  logic                stall,
    input  logic                branch,
    input  logic                zero,
    input  logic                jump,
    input  logic [15:0]         branch_imm,
    input  logic [25:0]         jump_target,
    output logic [31:0]         instr,
    output logic [5:0]          opcode,
    output logic                instr_valid,
    output logic [ADDR_W-1:0]   pc,
    output logic                fetch_fault
);
    localparam int                WAIT_W   = (MAX_WAIT > 1) ? $clog2(MAX_WAIT) : 1;
    localparam logic [ADDR_W-1:0] PC_INIT  = {RESET_PC[ADDR_W-1:2], 2'b00};
    localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MAX_WAIT - 1);

    fetch_state_e      state;
    logic [WAIT_W-1:0] wait_cnt;
    logic [ADDR_W-1:0] next_pc;

    next_pc_calc #(.ADDR_W(ADDR_W)) u_next_pc (
        .pc          (pc),
        .jump        (jump),
        .branch      (branch),
        .zero        (zero),
        .branch_imm  (branch_imm),
        .jump_target (jump_target),
        .next_pc     (next_pc)
    );

    assign imem.imem_addr = pc;
    assign opcode         = opcode_of(instr);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= ST_REQ;
            pc            <= PC_INIT;
            instr         <= '0;
            instr_valid   <= 1'b0;
            imem.imem_req <= 1'b0;
            fetch_fault   <= 1'b0;
            wait_cnt      <= '0;
        end else begin
            case (state)
                ST_REQ: begin
                    // First cycle out of reset only raises the request; a stale ack is ignored.
                    if (!imem.imem_req) begin
                        imem.imem_req <= 1'b1;
                    end else if (imem.imem_ack) begin
                        instr         <= imem.imem_rdata;
                        wait_cnt      <= '0;
                        imem.imem_req <= 1'b0;
                        instr_valid   <= 1'b1;
                        state         <= ST_ISSUE;
                    end else if (wait_cnt == WAIT_MAX) begin
                        wait_cnt      <= '0;
                        imem.imem_req <= 1'b0;
                        fetch_fault   <= 1'b1;
                        state         <= ST_FAULT;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                ST_ISSUE: begin
                    if (!stall) begin
                        pc            <= next_pc;
                        instr_valid   <= 1'b0;
                        imem.imem_req <= 1'b1;
                        state         <= ST_REQ;
                    end
                end
                ST_FAULT: begin
                    imem.imem_req <= 1'b0;
                    instr_valid   <= 1'b0;
                    fetch_fault   <= 1'b1;
                end
                default: begin
                    state <= ST_REQ;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit with a scoreboard of fetched (pc, instr) pairs.
module tb_instr_fetch_unit;
    import instr_fetch_unit_pkg::*;

    localparam int ADDR_W = 32;

    logic              clk = 1'b0;
    logic              reset;
    logic              stall, branch, zero, jump;
    logic [15:0]       branch_imm;
    logic [25:0]       jump_target;
    logic [31:0]       instr;
    logic [5:0]        opcode;
    logic              instr_valid;
    logic [ADDR_W-1:0] pc;
    logic              fetch_fault;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } exp_t;
    exp_t sb[$];

    always #5 clk = ~clk;

    instr_fetch_unit_if #(.ADDR_W(ADDR_W)) bus ();

    instr_fetch_unit #(
        .ADDR_W   (ADDR_W),
        .RESET_PC (32'h0000_0000),
        .MAX_WAIT (8)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .imem        (bus),
        .stall       (stall),
        .branch      (branch),
        .zero        (zero),
        .jump        (jump),
        .branch_imm  (branch_imm),
        .jump_target (jump_target),
        .instr       (instr),
        .opcode      (opcode),
        .instr_valid (instr_valid),
        .pc          (pc),
        .fetch_fault (fetch_fault)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic wait_req(input string tag);
        int n = 0;
        while (bus.imem_req !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_req_up"}, bus.imem_req, 1'b1);
    endtask

    // One complete instruction: request, optional ack delay, issue with optional stall, redirect.
    task automatic fetch(input string tag, input int delay, input logic [31:0] word,
                         input int nstall, input logic j, input logic b, input logic z,
                         input logic [15:0] imm, input logic [25:0] tgt,
                         input logic [31:0] exp_pc, input logic [31:0] exp_next);
        exp_t e;
        exp_t got;
        wait_req(tag);
        check({tag, "_addr"}, bus.imem_addr, exp_pc);
        for (int i = 0; i < delay; i++) begin
            @(posedge clk);
            @(negedge clk);
            check({tag, "_wait_req"}, bus.imem_req, 1'b1);
            check({tag, "_wait_addr"}, bus.imem_addr, exp_pc);
        end
        bus.imem_ack   = 1'b1;
        bus.imem_rdata = word;
        stall          = (nstall > 0);
        jump           = j;
        branch         = b;
        zero           = z;
        branch_imm     = imm;
        jump_target    = tgt;
        e.pc    = exp_pc;
        e.instr = word;
        sb.push_back(e);
        @(posedge clk);
        #1;
        bus.imem_ack   = 1'b0;
        bus.imem_rdata = 32'hDEAD_BEEF;
        @(negedge clk);
        check({tag, "_valid"}, instr_valid, 1'b1);
        check({tag, "_req_low"}, bus.imem_req, 1'b0);
        check({tag, "_ctrl_known"}, $isunknown({jump, branch, zero}), 1'b0);
        if (instr_valid === 1'b1 && sb.size() > 0) begin
            got = sb.pop_front();
            check({tag, "_pc"}, pc, got.pc);
            check({tag, "_instr"}, instr, got.instr);
            check({tag, "_opcode"}, opcode, got.instr[31:26]);
        end else begin
            checks++;
            errors++;
            $error("FAIL %s_sb observed valid=%b queued=%0d expected a valid fetch", tag, instr_valid, sb.size());
        end
        // Acks arriving while the instruction is stalled must not disturb it.
        bus.imem_ack   = (nstall > 0);
        bus.imem_rdata = ~word;
        for (int k = 0; k < nstall; k++) begin
            @(posedge clk);
            #1;
            if (k == nstall - 1) begin
                stall        = 1'b0;
                bus.imem_ack = 1'b0;
            end
            @(negedge clk);
            check({tag, "_stall_valid"}, instr_valid, 1'b1);
            check({tag, "_stall_req"}, bus.imem_req, 1'b0);
            check({tag, "_stall_instr"}, instr, word);
            check({tag, "_stall_pc"}, pc, exp_pc);
        end
        @(posedge clk);
        #1;
        jump   = 1'b0;
        branch = 1'b0;
        zero   = 1'b0;
        @(negedge clk);
        check({tag, "_valid_drop"}, instr_valid, 1'b0);
        check({tag, "_next_req"}, bus.imem_req, 1'b1);
        check({tag, "_next_pc"}, bus.imem_addr, exp_next);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        reset          = 1'b1;
        bus.imem_ack   = 1'b0;
        bus.imem_rdata = '0;
        stall          = 1'b0;
        branch         = 1'b0;
        zero           = 1'b0;
        jump           = 1'b0;
        branch_imm     = '0;
        jump_target    = '0;

        repeat (3) begin
            @(negedge clk);
            check("rst_req", bus.imem_req, 1'b0);
            check("rst_valid", instr_valid, 1'b0);
            check("rst_fault", fetch_fault, 1'b0);
            check("rst_pc", pc, 32'h0);
            check("rst_instr", instr, 32'h0);
        end
        reset = 1'b0;
        #1;
        check("rel_req_low", bus.imem_req, 1'b0);
        @(negedge clk);
        check("rel_req_high", bus.imem_req, 1'b1);
        check("rel_addr", bus.imem_addr, 32'h0);

        fetch("seq0", 0, 32'h3800_0005, 0, 1'b0, 1'b0, 1'b0, 16'h0, 26'h0, 32'h0, 32'h4);
        check("seq0_lw", opcode, OP_LW);
        fetch("seq1", 3, 32'h3800_0005, 0, 1'b0, 1'b0, 1'b0, 16'h0, 26'h0, 32'h4, 32'h8);
        fetch("jmp40", 1, 32'h4400_0010, 0, 1'b1, 1'b0, 1'b0, 16'h0, 26'h10, 32'h8, 32'h40);
        fetch("br_taken", 0, 32'h4000_FFFF, 0, 1'b0, 1'b1, 1'b1, 16'hFFFF, 26'h0, 32'h40, 32'h40);
        fetch("br_not", 2, 32'h4000_FFFF, 0, 1'b0, 1'b1, 1'b0, 16'hFFFF, 26'h0, 32'h40, 32'h44);
        fetch("br_min", 0, 32'h4000_8000, 0, 1'b0, 1'b1, 1'b1, 16'h8000, 26'h0, 32'h44, 32'hFFFE_0048);
        fetch("jmp_hi", 0, 32'h4400_0004, 0, 1'b1, 1'b0, 1'b0, 16'h0, 26'h4, 32'hFFFE_0048, 32'hF000_0010);
        fetch("jmp_wins", 1, 32'hFC00_0000, 4, 1'b1, 1'b1, 1'b1, 16'h0010, 26'h100, 32'hF000_0010, 32'hF000_0400);
        fetch("jmp_top", 0, 32'h4700_0000, 0, 1'b1, 1'b0, 1'b0, 16'h0, 26'h3FF_FFFF, 32'hF000_0400, 32'hFFFF_FFFC);
        fetch("wrap", 0, 32'h0000_0020, 0, 1'b0, 1'b0, 1'b0, 16'h0, 26'h0, 32'hFFFF_FFFC, 32'h0);

        // Reset in the middle of an unanswered request, with a late ack afterwards.
        repeat (3) @(negedge clk);
        check("mid_req", bus.imem_req, 1'b1);
        #2;
        reset = 1'b1;
        #1;
        check("mid_rst_req", bus.imem_req, 1'b0);
        check("mid_rst_valid", instr_valid, 1'b0);
        check("mid_rst_pc", pc, 32'h0);
        bus.imem_ack   = 1'b1;
        bus.imem_rdata = 32'hFFFF_FFFF;
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        bus.imem_ack = 1'b0;
        @(negedge clk);
        check("late_ack_req", bus.imem_req, 1'b1);
        check("late_ack_valid", instr_valid, 1'b0);
        check("late_ack_instr", instr, 32'h0);
        fetch("post_rst", 0, 32'h0000_0001, 0, 1'b0, 1'b0, 1'b0, 16'h0, 26'h0, 32'h0, 32'h4);

        // Memory never answers: fault after MAX_WAIT request cycles.
        n = 0;
        while (bus.imem_req === 1'b1 && n < 20) begin
            n++;
            @(negedge clk);
        end
        check("fault_cycles", n, 8);
        check("fault_flag", fetch_fault, 1'b1);
        check("fault_valid", instr_valid, 1'b0);
        repeat (3) begin
            @(negedge clk);
            check("fault_sticky", fetch_fault, 1'b1);
            check("fault_req", bus.imem_req, 1'b0);
        end
        #2;
        reset = 1'b1;
        #1;
        check("fault_clr", fetch_fault, 1'b0);
        check("fault_clr_pc", pc, 32'h0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("fault_rst_req", bus.imem_req, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
